// File: rtl/board_cursor.sv
// Maps the mouse pointer onto a parametrised board grid and runs a click-driven
// pick/place state machine that reports source and destination squares.
module board_cursor #(
    parameter int BOARD_X0 = 256,
    parameter int BOARD_Y0 = 128,
    parameter int SQ_LOG2  = 6,
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int SQ_W    = COL_W + ROW_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lmb,
    input  logic            rmb,
    input  logic [11:0]     mouse_xpos,
    input  logic [11:0]     mouse_ypos,
    output logic [SQ_W-1:0] square,
    output logic            on_board,
    output logic            holding,
    output logic [SQ_W-1:0] src_square,
    output logic [SQ_W-1:0] dst_square,
    output logic            pick_pulse,
    output logic            place_pulse,
    output logic            cancel_pulse
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state;
    logic               lmb_q;
    logic               rmb_q;
    logic               click_q;
    logic               rclick_q;
    logic signed [12:0] dx;
    logic signed [12:0] dy;
    logic signed [12:0] col;
    logic signed [12:0] row;
    logic               in_board;

    // Offsets are 13-bit signed so pointers left of / above the origin go negative.
    assign dx  = signed'({1'b0, mouse_xpos} - 13'(BOARD_X0));
    assign dy  = signed'({1'b0, mouse_ypos} - 13'(BOARD_Y0));
    assign col = dx >>> SQ_LOG2;
    assign row = dy >>> SQ_LOG2;

    assign in_board = !dx[12] && !dy[12] &&
                      ($unsigned(col) < 13'(COLS)) &&
                      ($unsigned(row) < 13'(ROWS));

    assign holding = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lmb_q        <= 1'b0;
            rmb_q        <= 1'b0;
            click_q      <= 1'b0;
            rclick_q     <= 1'b0;
            square       <= '0;
            on_board     <= 1'b0;
            src_square   <= '0;
            dst_square   <= '0;
            pick_pulse   <= 1'b0;
            place_pulse  <= 1'b0;
            cancel_pulse <= 1'b0;
        end else begin
            lmb_q    <= lmb;
            rmb_q    <= rmb;
            // Edge flags are registered so they line up with the registered square.
            click_q  <= lmb_q & ~lmb;
            rclick_q <= ~rmb_q & rmb;

            on_board <= in_board;
            if (in_board) begin
                square <= {col[COL_W-1:0], row[ROW_W-1:0]};
            end

            pick_pulse   <= 1'b0;
            place_pulse  <= 1'b0;
            cancel_pulse <= 1'b0;

            if (state == IDLE) begin
                if (click_q && on_board) begin
                    pick_pulse <= 1'b1;
                    src_square <= square;
                    state      <= HOLD;
                end
            end else begin
                if (rclick_q) begin
                    cancel_pulse <= 1'b1;
                    state        <= IDLE;
                end else if (click_q && on_board) begin
                    if (square != src_square) begin
                        place_pulse <= 1'b1;
                        dst_square  <= square;
                    end else begin
                        cancel_pulse <= 1'b1;
                    end
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: doc/board_cursor.md
# board_cursor

Parametrised successor of the fixed 8×8 mouse-to-square mapper. Converts the mouse pointer position into a board square index for a configurable board origin, square size and board dimensions, and flags off-board positions. A click-driven pick/place state machine reports source and destination squares, with cancel via right button or a re-click on the source. Sits between the mouse interface and the game-logic/rendering blocks in the VGA pipeline.

## Interface

Parameters:
- BOARD_X0, default 256: pixel x of the left edge of column 0.
- BOARD_Y0, default 128: pixel y of the top edge of row 0.
- SQ_LOG2, default 6: log2 of the square size in pixels (6 gives 64 px).
- COLS, default 8: number of board columns, from 1 to 2**COL_W.
- ROWS, default 8: number of board rows, from 1 to 2**ROW_W.
- Derived: COL_W = max(1, $clog2(COLS)); ROW_W = max(1, $clog2(ROWS)); SQ_W = COL_W + ROW_W.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- lmb  in  1  left mouse button level, already synchronised to clk.
- rmb  in  1  right mouse button level, already synchronised to clk.
- mouse_xpos  in  12  pointer x in pixels.
- mouse_ypos  in  12  pointer y in pixels.
- square  out  SQ_W  square under the pointer, {col, row}, with col in the upper COL_W bits.
- on_board  out  1  pointer lies inside the board area.
- holding  out  1  a piece is picked and awaits placement.
- src_square  out  SQ_W  square latched at pick.
- dst_square  out  SQ_W  square latched at place.
- pick_pulse  out  1  one-cycle pulse on a valid pick.
- place_pulse  out  1  one-cycle pulse on a valid place.
- cancel_pulse  out  1  one-cycle pulse when a held pick is dropped.

## Operation

- Mapping:
  - dx = {1'b0, mouse_xpos} − BOARD_X0 in 13-bit signed arithmetic; dy is computed the same way from mouse_ypos and BOARD_Y0.
  - col = dx >>> SQ_LOG2 and row = dy >>> SQ_LOG2. No dividers are used.
  - In-board test: dx ≥ 0, dy ≥ 0, col < COLS and row < ROWS.
  - When in board: square ← {col[COL_W-1:0], row[ROW_W-1:0]} and on_board ← 1.
  - When off board: on_board ← 0 and square holds its last in-board value.
- Click detection:
  - Registers lmb_q and rmb_q hold the previous button levels.
  - click = lmb_q & ~lmb, i.e. the release edge.
  - rclick = ~rmb_q & rmb, i.e. the press edge.
- The FSM evaluates clicks against the registered square and on_board values from the same cycle.
- FSM states: IDLE and HOLD; holding = (state == HOLD).
  - IDLE, click with on_board=1: pick_pulse, src_square ← square, go to HOLD.
  - IDLE, click with on_board=0: ignored.
  - IDLE, rclick: ignored.
  - HOLD, rclick: cancel_pulse, go to IDLE. rclick has priority over a simultaneous click.
  - HOLD, click with on_board=1 and square ≠ src_square: place_pulse, dst_square ← square, go to IDLE.
  - HOLD, click with on_board=1 and square == src_square: cancel_pulse, go to IDLE.
  - HOLD, click with on_board=0: ignored; stays in HOLD.
- At most one of pick_pulse, place_pulse and cancel_pulse is high in any cycle.

## Timing

- Reset: every output and every internal register is 0, including lmb_q and rmb_q. state = IDLE.
  - A button already held when reset is released does not generate a click until it is released after lmb_q has been captured as 1.
- square and on_board appear 1 cycle after mouse_xpos/mouse_ypos are sampled.
- Pulses are registered:
  - They are asserted in the cycle after the edge is detected, i.e. 2 cycles after lmb first samples 0 or rmb first samples 1.
  - They last exactly 1 cycle.
- src_square and dst_square update in the same cycle as their pulse and hold until the next pick or place.
- holding rises with pick_pulse and falls with place_pulse or cancel_pulse.
- Reset asserted mid-HOLD returns the block to IDLE with no cancel_pulse.
- Holding a button does not auto-repeat; each press/release pair counts once.

## Test plan

- Mapping with defaults: (x=300, y=200) → square=6'd1, on_board=1. (x=767, y=639) → square=6'd63. (x=768, y=300) → on_board=0 and square stays 63.
- Negative offset: (x=255, y=127) → on_board=0. Feed (x=256, y=128) next → square=0, on_board=1 one cycle later.
- Pick/place: click at (320,128), giving square {1,0}=6'd8 → pick_pulse, src_square=8, holding=1. Then click at (448,384), giving {3,4}=6'd28 → place_pulse, dst_square=28, holding=0. Each pulse is exactly 1 cycle.
- Cancel paths: pick at square 8, then click on square 8 → cancel_pulse. Pick again, then press rmb and release lmb in the same cycle → cancel_pulse only, no place_pulse.
- Off-board clicks: in IDLE, click at (100,100) → no pulse. In HOLD, click at (100,100) → no pulse and holding stays 1.
- Parameter sweep with COLS=10, ROWS=6, SQ_LOG2=5, BOARD_X0=0, BOARD_Y0=0:
  - (x=319, y=191) → col=9, row=5 → square={4'd9, 3'd5}.
  - (x=320, y=0) → on_board=0.
  - Also assert rst during HOLD → holding=0 and no pulses.
